// File: rtl/matmul_engine_pkg.sv
// Shared types and sizing for the matrix-multiply engine: FSM encoding,
// default matrix dimensions, datapath widths and flat-index helper.
package matmul_engine_pkg;

  localparam int DEF_ROW   = 2;
  localparam int DEF_INNER = 2;
  localparam int DEF_COL   = 2;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  // Row-major flattening: row * width + col, truncated to the address width.
  function automatic logic [ADDR_W-1:0] flat_index(input logic [ADDR_W-1:0] row,
                                                   input logic [ADDR_W-1:0] col,
                                                   input int unsigned width);
    return ADDR_W'(32'(row) * width + 32'(col));
  endfunction

endpackage

// File: rtl/matmul_engine_level_det.sv
// Rising-edge detector for a level request; emits a registered one-cycle
// pulse the cycle after the low-to-high transition is sampled.
module level_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= in;
      rise <= in & ~prev;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Sequential R = A x B engine: one multiply-accumulate per three cycles,
// reading A/B from synchronous memories and writing R in row-major order.
module matmul_engine
  import matmul_engine_pkg::*;
#(
  parameter int ROW   = DEF_ROW,
  parameter int INNER = DEF_INNER,
  parameter int COL   = DEF_COL
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              start,
  output logic              read_A,
  output logic [ADDR_W-1:0] read_address_A,
  input  logic [DATA_W-1:0] data_A,
  output logic              read_B,
  output logic [ADDR_W-1:0] read_address_B,
  input  logic [DATA_W-1:0] data_B,
  output logic              write_R,
  output logic [ADDR_W-1:0] write_address_R,
  output logic [RES_W-1:0]  write_value_R,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int ACC_W = RES_W + $clog2(INNER);
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(ROW - 1);
  localparam logic [ADDR_W-1:0] J_LAST = ADDR_W'(COL - 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(INNER - 1);

  state_t              state;
  logic [ADDR_W-1:0]   i, j, k;
  logic [ACC_W-1:0]    acc;
  logic [DATA_W-1:0]   a_val, b_val;
  logic                start_rise;

  logic [RES_W-1:0]    prod;
  logic [ACC_W-1:0]    acc_sum;
  logic [ADDR_W-1:0]   k_inc, i_adv, j_adv;
  logic                j_wrap, last_elem;

  level_det u_level_det (
    .clk  (slow_clk),
    .rst  (rst),
    .in   (start),
    .rise (start_rise)
  );

  assign prod      = RES_W'(a_val) * RES_W'(b_val);
  assign acc_sum   = acc + ACC_W'(prod);
  assign k_inc     = k + 1'b1;
  assign j_wrap    = (j == J_LAST);
  assign last_elem = j_wrap && (i == I_LAST);
  assign j_adv     = j_wrap ? '0 : j + 1'b1;
  assign i_adv     = j_wrap ? ((i == I_LAST) ? '0 : i + 1'b1) : i;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      i               <= '0;
      j               <= '0;
      k               <= '0;
      acc             <= '0;
      a_val           <= '0;
      b_val           <= '0;
      read_A          <= 1'b0;
      read_B          <= 1'b0;
      read_address_A  <= '0;
      read_address_B  <= '0;
      write_R         <= 1'b0;
      write_address_R <= '0;
      write_value_R   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      // Strobes and addresses are one-cycle; they only rise on state entry.
      read_A          <= 1'b0;
      read_B          <= 1'b0;
      read_address_A  <= '0;
      read_address_B  <= '0;
      write_R         <= 1'b0;
      write_address_R <= '0;
      write_value_R   <= '0;
      done            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_rise) begin
            i              <= '0;
            j              <= '0;
            k              <= '0;
            acc            <= '0;
            overflow       <= 1'b0;
            busy           <= 1'b1;
            read_A         <= 1'b1;
            read_B         <= 1'b1;
            read_address_A <= flat_index('0, '0, INNER);
            read_address_B <= flat_index('0, '0, COL);
            state          <= S_FETCH;
          end
        end

        S_FETCH: state <= S_WAIT;

        S_WAIT: begin
          a_val <= data_A;
          b_val <= data_B;
          state <= S_MAC;
        end

        S_MAC: begin
          acc <= acc_sum;
          if (k == K_LAST) begin
            write_R         <= 1'b1;
            write_address_R <= flat_index(i, j, COL);
            write_value_R   <= acc_sum[RES_W-1:0];
            if (|(acc_sum >> RES_W)) overflow <= 1'b1;
            state <= S_WRITE;
          end else begin
            k              <= k_inc;
            read_A         <= 1'b1;
            read_B         <= 1'b1;
            read_address_A <= flat_index(i, k_inc, INNER);
            read_address_B <= flat_index(k_inc, j, COL);
            state          <= S_FETCH;
          end
        end

        S_WRITE: begin
          acc <= '0;
          k   <= '0;
          j   <= j_adv;
          i   <= i_adv;
          if (last_elem) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            read_A         <= 1'b1;
            read_B         <= 1'b1;
            read_address_A <= flat_index(i_adv, '0, INNER);
            read_address_B <= flat_index('0, j_adv, COL);
            state          <= S_FETCH;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
